ddr2_64bit_local_master: RTL and testbench

Initiator for the controller's local (Avalon-style burst) port. It accepts simple read and write burst commands from an internal client and drives `local_*` with the burst handshake rules the controller requires. It tracks outstanding read beats and tags the read-return stream with burst boundaries. It sits between the client fabric and `ddr2_64bit_controller_phy`, running on `phy_clk`.

---
 rtl/ddr2_64bit_local_master.sv | 211 +++++++++++++++++++++
 tb/tb_ddr2_64bit_local_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_64bit_local_master.sv
// rtl/ddr2_64bit_local_master.sv - burst initiator for the controller local port
module ddr2_64bit_local_master #(
    parameter int ADDR_W          = 26,
    parameter int DATA_W          = 128,
    parameter int BE_W            = 16,
    parameter int SIZE_W          = 6,
    parameter int MAX_BURST       = 32,
    parameter int MAX_OUTSTANDING = 64,
    parameter int LEN_FIFO_DEPTH  = 4
) (
    input  logic              phy_clk,
    input  logic              reset_phy_clk_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [SIZE_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              err,
    input  logic              local_init_done,
    input  logic              local_ready,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    output logic [ADDR_W-1:0] local_address,
    output logic [SIZE_W-1:0] local_size,
    output logic              local_read_req,
    output logic              local_write_req,
    output logic              local_burstbegin,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = $clog2(LEN_FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_REQ,
        ST_WR_BURST
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [SIZE_W-1:0]   beat_q, beat_d;
    logic [SIZE_W-1:0]   ret_q, ret_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic [PTR_W:0]      wptr_q, wptr_d;
    logic [PTR_W:0]      rptr_q, rptr_d;
    logic [SIZE_W-1:0]   fifo_q [LEN_FIFO_DEPTH];
    logic [SIZE_W-1:0]   fifo_d [LEN_FIFO_DEPTH];
    logic                err_q, err_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                fifo_full;
    logic [PTR_W:0]      fifo_count;
    logic [SIZE_W-1:0]   fifo_head;
    logic                accept;
    logic                len_bad;
    logic                rd_issue;
    logic                wr_beat;
    logic                ret_ok;
    logic                ret_last;

    // Handshake qualifiers, credit check and combinational bus outputs
    always_comb begin
        fifo_count       = wptr_q - rptr_q;
        fifo_full        = (fifo_count == (PTR_W+1)'(LEN_FIFO_DEPTH));
        fifo_head        = fifo_q[rptr_q[PTR_W-1:0]];
        // Keeps room for one more maximal burst so outstanding cannot overflow.
        cmd_ready        = (state_q == ST_IDLE)
                         && (out_q <= OUT_W'(MAX_OUTSTANDING - MAX_BURST))
                         && !fifo_full;
        accept           = cmd_valid && cmd_ready;
        len_bad          = (cmd_len == '0) || (cmd_len > SIZE_W'(MAX_BURST));
        rd_issue         = (state_q == ST_RD_REQ) && local_ready;
        wr_beat          = (state_q == ST_WR_BURST) && wr_valid && local_ready;
        // A return beat with nothing outstanding is forwarded but never counted.
        ret_ok           = local_rdata_valid && (out_q != '0);
        ret_last         = ret_ok && (ret_q == fifo_head - SIZE_W'(1));

        local_read_req   = (state_q == ST_RD_REQ);
        local_write_req  = (state_q == ST_WR_BURST) && wr_valid;
        local_burstbegin = local_read_req || (local_write_req && (beat_q == '0));
        wr_ready         = (state_q == ST_WR_BURST) && local_ready;
        local_wdata      = wr_data;
        local_be         = wr_be;
        local_address    = addr_q;
        local_size       = size_q;
        rd_valid         = rd_valid_q;
        rd_last          = rd_last_q;
        rd_data          = rd_data_q;
        err              = err_q;
    end

    // Next-state: command FSM, credit counter, length FIFO and read-return tagging
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        beat_d     = beat_q;
        ret_d      = ret_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fifo_d     = fifo_q;
        err_d      = err_q;
        rd_valid_d = local_rdata_valid;
        rd_last_d  = ret_last;
        rd_data_d  = local_rdata_valid ? local_rdata : rd_data_q;

        out_d = out_q + (rd_issue ? OUT_W'(size_q) : '0) - (ret_ok ? OUT_W'(1) : '0);

        if (accept && len_bad) begin
            err_d = 1'b1;
        end
        if (local_rdata_valid && (out_q == '0)) begin
            err_d = 1'b1;
        end

        if (rd_issue) begin
            fifo_d[wptr_q[PTR_W-1:0]] = size_q;
            wptr_d = wptr_q + (PTR_W+1)'(1);
        end

        if (ret_last) begin
            ret_d  = '0;
            rptr_d = rptr_q + (PTR_W+1)'(1);
        end else if (ret_ok) begin
            ret_d  = ret_q + SIZE_W'(1);
        end

        case (state_q)
            ST_INIT: begin
                if (local_init_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    addr_d = cmd_addr;
                    size_d = cmd_len;
                    if (!len_bad) begin
                        beat_d  = '0;
                        state_d = cmd_write ? ST_WR_BURST : ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (local_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_BURST: begin
                if (wr_beat) begin
                    if (beat_q == size_q - SIZE_W'(1)) begin
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d  = beat_q + SIZE_W'(1);
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State registers; reset abandons any burst and discards outstanding reads
    always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
        if (!reset_phy_clk_n) begin
            state_q    <= ST_INIT;
            addr_q     <= '0;
            size_q     <= '0;
            beat_q     <= '0;
            ret_q      <= '0;
            out_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            for (int i = 0; i < LEN_FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            beat_q     <= beat_d;
            ret_q      <= ret_d;
            out_q      <= out_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fifo_q     <= fifo_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_ddr2_64bit_local_master.sv
// tb/tb_ddr2_64bit_local_master.sv - directed self-checking bench for ddr2_64bit_local_master
module tb_ddr2_64bit_local_master;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [25:0]  cmd_addr;
    logic [5:0]   cmd_len;
    logic         wr_valid, wr_ready;
    logic [127:0] wr_data;
    logic [15:0]  wr_be;
    logic [127:0] rd_data;
    logic         rd_valid, rd_last, err;
    logic         local_init_done, local_ready;
    logic [127:0] local_rdata;
    logic         local_rdata_valid;
    logic [25:0]  local_address;
    logic [5:0]   local_size;
    logic         local_read_req, local_write_req, local_burstbegin;
    logic [127:0] local_wdata;
    logic [15:0]  local_be;

    int total = 0;
    int bad   = 0;

    ddr2_64bit_local_master dut (
        .phy_clk           (clk),
        .reset_phy_clk_n   (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .wr_be             (wr_be),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .rd_last           (rd_last),
        .err               (err),
        .local_init_done   (local_init_done),
        .local_ready       (local_ready),
        .local_rdata       (local_rdata),
        .local_rdata_valid (local_rdata_valid),
        .local_address     (local_address),
        .local_size        (local_size),
        .local_read_req    (local_read_req),
        .local_write_req   (local_write_req),
        .local_burstbegin  (local_burstbegin),
        .local_wdata       (local_wdata),
        .local_be          (local_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        local_init_done = 1'b0;
        cmd_valid = 1'b0;
        wr_valid = 1'b0;
        local_rdata_valid = 1'b0;
        local_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        local_init_done = 1'b1;
        step();
        step();
        @(negedge clk);
    endtask

    // Write burst stimulus and expectations, one row per bus cycle
    bit wv   [7] = '{1, 0, 1, 1, 1, 1, 0};
    bit lr   [7] = '{1, 1, 0, 1, 0, 1, 1};
    int bidx [7] = '{0, 0, 1, 1, 2, 2, 0};
    bit bb   [7] = '{1, 0, 0, 0, 0, 0, 0};
    bit wrdy [7] = '{1, 1, 0, 1, 0, 1, 0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nlast;
        int n;
        int nbeats;
        logic [127:0] exp_d;

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_be = '0;
        local_init_done = 1'b0; local_ready = 1'b0;
        local_rdata = '0; local_rdata_valid = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_err", err, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_read_req", local_read_req, 0);
        check("rst_write_req", local_write_req, 0);
        check("rst_burstbegin", local_burstbegin, 0);
        check("rst_address", local_address, 0);
        check("rst_size", local_size, 0);

        // Init gating with a read command waiting
        step();
        rst_n = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 26'h0001000; cmd_len = 6'd4;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("init_gate", cmd_ready, 0);
            step();
        end
        local_init_done = 1'b1;
        @(negedge clk);
        check("init_not_yet", cmd_ready, 0);
        step();
        @(negedge clk);
        check("init_ready", cmd_ready, 1);
        check("init_no_req", local_read_req, 0);

        // Read burst: request held through local_ready 0,0,1
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rd_req_c0", local_read_req, 1);
        check("rd_bb_c0", local_burstbegin, 1);
        check("rd_addr", local_address, 26'h0001000);
        check("rd_size", local_size, 4);
        check("rd_busy", cmd_ready, 0);
        step();
        @(negedge clk);
        check("rd_req_c1", local_read_req, 1);
        check("rd_bb_c1", local_burstbegin, 1);
        step();
        local_ready = 1'b1;
        @(negedge clk);
        check("rd_req_c2", local_read_req, 1);
        check("rd_bb_c2", local_burstbegin, 1);
        step();
        @(negedge clk);
        check("rd_req_done", local_read_req, 0);
        check("rd_idle_ready", cmd_ready, 1);

        // Four return beats, registered by one cycle
        for (int i = 0; i < 5; i++) begin
            step();
            local_rdata_valid = (i < 4);
            local_rdata = {4{32'hD00D_0000 + i}};
            @(negedge clk);
            if (i > 0) begin
                exp_d = {4{32'hD00D_0000 + i - 1}};
                check("ret_valid", rd_valid, 1);
                check("ret_data", rd_data, exp_d);
                check("ret_last", rd_last, (i == 4));
            end
        end
        step();
        @(negedge clk);
        check("ret_valid_off", rd_valid, 0);
        check("ret_err", err, 0);

        // Write burst len 3 with gaps and stalls
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 26'h0002000; cmd_len = 6'd3;
        @(negedge clk);
        check("wr_accept", cmd_ready, 1);
        nbeats = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            cmd_valid = 1'b0;
            wr_valid = wv[c];
            local_ready = lr[c];
            wr_data = {4{32'hA000_0000 + bidx[c]}};
            wr_be = 16'h0F0F + 16'(bidx[c]);
            @(negedge clk);
            exp_d = {4{32'hA000_0000 + bidx[c]}};
            check("wr_req", local_write_req, (c < 6) && wv[c]);
            check("wr_bb", local_burstbegin, bb[c]);
            check("wr_ready", wr_ready, wrdy[c]);
            if (c < 6 && wv[c]) begin
                check("wr_data", local_wdata, exp_d);
                check("wr_be", local_be, 16'h0F0F + 16'(bidx[c]));
            end
            if (c == 0) begin
                check("wr_addr", local_address, 26'h0002000);
                check("wr_size", local_size, 3);
                check("wr_busy", cmd_ready, 0);
            end
            if (local_write_req && local_ready) nbeats++;
        end
        check("wr_beats", nbeats, 3);
        check("wr_idle", cmd_ready, 1);

        // Credit limit: two len-32 reads with no returns
        step();
        wr_valid = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 26'h0004000; cmd_len = 6'd32;
        local_ready = 1'b1;
        @(negedge clk);
        check("cr_acc1", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("cr_req1", local_read_req, 1);
        step();
        cmd_valid = 1'b1; cmd_addr = 26'h0004100;
        @(negedge clk);
        check("cr_acc2", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("cr_req2", local_read_req, 1);
        step();
        @(negedge clk);
        check("cr_full", cmd_ready, 0);

        nlast = 0;
        for (int k = 0; k < 31; k++) begin
            step();
            local_rdata_valid = 1'b1;
            local_rdata = 128'(k);
            @(negedge clk);
            nlast += int'(rd_last);
        end
        step();
        local_rdata_valid = 1'b0;
        @(negedge clk);
        nlast += int'(rd_last);
        check("cr_33", cmd_ready, 0);
        check("cr_no_last", nlast, 0);
        step();
        local_rdata_valid = 1'b1;
        @(negedge clk);
        check("cr_33b", cmd_ready, 0);
        step();
        local_rdata_valid = 1'b0;
        @(negedge clk);
        check("cr_last1", rd_last, 1);
        check("cr_32", cmd_ready, 1);

        // Third read issued in the same cycle as a return beat: net 32+32-1
        step();
        cmd_valid = 1'b1; cmd_addr = 26'h0004200; local_ready = 1'b0;
        @(negedge clk);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("sc_req", local_read_req, 1);
        step();
        local_ready = 1'b1;
        local_rdata_valid = 1'b1;
        @(negedge clk);
        step();
        local_rdata_valid = 1'b0;
        @(negedge clk);
        check("sc_63", cmd_ready, 0);
        n = 0;
        nlast = 0;
        while (n < 100) begin
            step();
            local_rdata_valid = 1'b1;
            @(negedge clk);
            step();
            local_rdata_valid = 1'b0;
            @(negedge clk);
            n++;
            nlast += int'(rd_last);
            if (cmd_ready) break;
        end
        check("sc_beats_to_32", n, 31);
        check("sc_last_cnt", nlast, 1);

        // Drain the third burst
        nlast = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            local_rdata_valid = 1'b1;
            @(negedge clk);
            nlast += int'(rd_last);
        end
        step();
        local_rdata_valid = 1'b0;
        @(negedge clk);
        nlast += int'(rd_last);
        check("drain_last", nlast, 1);
        check("drain_err", err, 0);

        // Error: zero length
        do_reset();
        check("e0_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_len = 6'd0; cmd_addr = 26'h0005000;
        @(negedge clk);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("e0_err", err, 1);
        check("e0_no_rd", local_read_req, 0);
        check("e0_idle", cmd_ready, 1);

        // Error: length above the maximum burst
        do_reset();
        check("e33_clear", err, 0);
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_len = 6'd33; wr_valid = 1'b1;
        @(negedge clk);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("e33_err", err, 1);
        check("e33_no_wr", local_write_req, 0);
        check("e33_size", local_size, 33);
        wr_valid = 1'b0;

        // Error: spurious return beat with nothing outstanding
        do_reset();
        step();
        local_rdata_valid = 1'b1;
        local_rdata = 128'h0000_BEEF;
        @(negedge clk);
        step();
        local_rdata_valid = 1'b0;
        @(negedge clk);
        check("sp_valid", rd_valid, 1);
        check("sp_data", rd_data, 128'h0000_BEEF);
        check("sp_last", rd_last, 0);
        check("sp_err", err, 1);
        repeat (5) step();
        @(negedge clk);
        check("sp_err_sticky", err, 1);
        check("sp_ready", cmd_ready, 1);

        // Reset in the middle of a len-8 write
        do_reset();
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_len = 6'd8; cmd_addr = 26'h0006000;
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            step();
            cmd_valid = 1'b0;
            wr_valid = 1'b1;
            local_ready = 1'b1;
            @(negedge clk);
        end
        check("mr_active", local_write_req, 1);
        check("mr_bb_beat2", local_burstbegin, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_wr_req", local_write_req, 0);
        check("mr_bb", local_burstbegin, 0);
        check("mr_wr_ready", wr_ready, 0);
        check("mr_cmd_ready", cmd_ready, 0);
        check("mr_addr", local_address, 0);
        check("mr_size", local_size, 0);
        check("mr_err", err, 0);
        local_init_done = 1'b0;
        wr_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        @(negedge clk);
        check("mr_init", cmd_ready, 0);
        step();
        local_init_done = 1'b1;
        step();
        @(negedge clk);
        check("mr_init_done", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
